// File: rtl/riscv_muldiv.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Shift-add multiply and restoring divide, UNROLL result bits per cycle;
// divide-by-zero and signed overflow complete through a one-cycle fast path.
module riscv_muldiv #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned UNROLL = 1
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_md_start,
  input  logic [2:0]      i_md_funct3,
  input  logic [XLEN-1:0] i_md_rs1,
  input  logic [XLEN-1:0] i_md_rs2,
  input  logic            i_md_kill,
  output logic            o_md_ready,
  output logic            o_md_busy,
  output logic            o_md_valid,
  output logic [XLEN-1:0] o_md_result
);

  localparam int unsigned N_ITER = XLEN / UNROLL;
  localparam int unsigned CW     = (N_ITER > 1) ? $clog2(N_ITER) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic                sign_a_q, sign_a_d;
  logic                sign_b_q, sign_b_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                accept;
  logic                is_div_in, signed_a_in, signed_b_in;
  logic                sa_in, sb_in;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, fast;
  logic [XLEN-1:0]     fast_result;

  logic [2*XLEN-1:0]   step_acc;
  logic [XLEN:0]       mul_hi;
  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       rem_diff;
  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     quot_fix, rem_fix;
  logic [XLEN-1:0]     calc_result;

  // Operand decode, magnitudes and fast-path detection for the incoming op
  always_comb begin
    accept      = (state_q != S_CALC) & i_md_start & ~i_md_kill;
    is_div_in   = i_md_funct3[2];
    signed_a_in = i_md_funct3[2] ? ~i_md_funct3[0]
                                 : (i_md_funct3[1:0] == 2'b01) | (i_md_funct3[1:0] == 2'b10);
    signed_b_in = i_md_funct3[2] ? ~i_md_funct3[0] : (i_md_funct3[1:0] == 2'b01);
    sa_in       = signed_a_in & i_md_rs1[XLEN-1];
    sb_in       = signed_b_in & i_md_rs2[XLEN-1];
    a_mag       = sa_in ? (XLEN'(0) - i_md_rs1) : i_md_rs1;
    b_mag       = sb_in ? (XLEN'(0) - i_md_rs2) : i_md_rs2;
    div_zero    = (i_md_rs2 == '0);
    div_ovf     = i_md_funct3[2] & ~i_md_funct3[0]
                & (i_md_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                & (i_md_rs2 == {XLEN{1'b1}});
    fast        = is_div_in & (div_zero | div_ovf);
    if (div_zero) begin
      fast_result = i_md_funct3[1] ? i_md_rs1 : {XLEN{1'b1}};
    end else begin
      fast_result = i_md_funct3[1] ? {XLEN{1'b0}} : i_md_rs1;
    end
  end

  // UNROLL iterations of shift-add (mul) or restoring shift-subtract (div)
  always_comb begin
    step_acc = acc_q;
    mul_hi   = '0;
    rem_sh   = '0;
    rem_diff = '0;
    for (int unsigned u = 0; u < UNROLL; u++) begin
      if (!op_q[2]) begin
        mul_hi   = {1'b0, step_acc[2*XLEN-1:XLEN]} + (step_acc[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
        step_acc = {mul_hi, step_acc[XLEN-1:1]};
      end else begin
        rem_sh   = {step_acc[2*XLEN-1:XLEN], step_acc[XLEN-1]};
        rem_diff = rem_sh - {1'b0, opnd_q};
        step_acc = {(rem_diff[XLEN] ? rem_sh[XLEN-1:0] : rem_diff[XLEN-1:0]),
                    step_acc[XLEN-2:0], ~rem_diff[XLEN]};
      end
    end
  end

  // Sign fix-up and result selection for the final CALC cycle
  always_comb begin
    prod_fix = (sign_a_q ^ sign_b_q) ? ((2*XLEN)'(0) - step_acc) : step_acc;
    quot_fix = (sign_a_q ^ sign_b_q) ? (XLEN'(0) - step_acc[XLEN-1:0]) : step_acc[XLEN-1:0];
    rem_fix  = sign_a_q ? (XLEN'(0) - step_acc[2*XLEN-1:XLEN]) : step_acc[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:                 calc_result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: calc_result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         calc_result = quot_fix;
      default:                calc_result = rem_fix;
    endcase
  end

  // State register and datapath flops
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CALC: begin
        if (i_md_kill)          state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_DONE;
        else                    state_d = S_CALC;
      end
      default: begin
        if (accept)             state_d = fast ? S_DONE : S_CALC;
        else                    state_d = S_IDLE;
      end
    endcase
  end

  // Datapath next values: latch on accept, iterate in CALC, write result on DONE entry
  always_comb begin
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (state_q == S_CALC) begin
      if (!i_md_kill) begin
        acc_d = step_acc;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) result_d = calc_result;
      end
    end else if (accept) begin
      op_d     = i_md_funct3;
      sign_a_d = sa_in;
      sign_b_d = sb_in;
      opnd_d   = is_div_in ? b_mag : a_mag;
      acc_d    = {{XLEN{1'b0}}, (is_div_in ? a_mag : b_mag)};
      cnt_d    = CW'(N_ITER - 1);
      if (fast) result_d = fast_result;
    end
  end

  // Status outputs decoded from the state register
  always_comb begin
    o_md_ready  = (state_q != S_CALC);
    o_md_busy   = (state_q == S_CALC);
    o_md_valid  = (state_q == S_DONE);
    o_md_result = result_q;
  end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv (UNROLL=1 and UNROLL=4 instances).
module tb_riscv_muldiv;

  logic        clk;
  logic        rst;
  logic        start, start4;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        kill;
  logic        ready, busy, valid;
  logic [31:0] result;
  logic        ready4, busy4, valid4;
  logic [31:0] result4;

  int checks = 0;
  int errors = 0;

  riscv_muldiv #(.XLEN(32), .UNROLL(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_md_start(start), .i_md_funct3(funct3),
    .i_md_rs1(rs1), .i_md_rs2(rs2), .i_md_kill(kill),
    .o_md_ready(ready), .o_md_busy(busy), .o_md_valid(valid), .o_md_result(result)
  );

  riscv_muldiv #(.XLEN(32), .UNROLL(4)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_md_start(start4), .i_md_funct3(funct3),
    .i_md_rs1(rs1), .i_md_rs2(rs2), .i_md_kill(kill),
    .o_md_ready(ready4), .o_md_busy(busy4), .o_md_valid(valid4), .o_md_result(result4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge
  task automatic issue(input bit which, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    funct3 = f3;
    rs1    = a;
    rs2    = b;
    if (which) start4 = 1'b1; else start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
    rs1    = 32'hDEAD_BEEF;
    rs2    = 32'h1234_5678;
    funct3 = 3'b000;
  endtask

  // Count cycles from accept to valid, and busy cycles in between
  task automatic wait_done(input bit which, input int exp_lat, input int exp_busy,
                           input logic [31:0] exp_res, input string tag);
    int  lat;
    int  nbusy;
    bit  seen;
    lat   = 0;
    nbusy = 0;
    seen  = 1'b0;
    for (int n = 1; n <= 60; n++) begin
      if (which ? valid4 : valid) begin
        seen = 1'b1;
        lat  = n;
        break;
      end
      if (which ? busy4 : busy) nbusy++;
      @(negedge clk);
    end
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " busy"}, 64'(nbusy), 64'(exp_busy));
    check({tag, " result"}, 64'(which ? result4 : result), 64'(exp_res));
  endtask

  initial begin
    int pulses;
    clk = 1'b0; rst = 1'b1; start = 1'b0; start4 = 1'b0; kill = 1'b0;
    funct3 = 3'b000; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ready", 64'(ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset valid", 64'(valid), 64'd0);
    check("reset result", 64'(result), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(0, 3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done(0, 33, 32, 32'hFFFF_FFEB, "MUL");
    @(negedge clk);
    check("MUL valid pulse width", 64'(valid), 64'd0);
    check("MUL result hold", 64'(result), 64'hFFFF_FFEB);

    issue(0, 3'b001, 32'h8000_0000, 32'h8000_0000);
    wait_done(0, 33, 32, 32'h4000_0000, "MULH");
    issue(0, 3'b011, 32'h8000_0000, 32'h8000_0000);
    wait_done(0, 33, 32, 32'h4000_0000, "MULHU");
    issue(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(0, 33, 32, 32'hFFFF_FFFF, "MULHSU");

    issue(0, 3'b100, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 33, 32, 32'hFFFF_FFFD, "DIV");
    issue(0, 3'b110, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 33, 32, 32'hFFFF_FFFF, "REM");
    issue(0, 3'b101, 32'd100, 32'd7);
    wait_done(0, 33, 32, 32'd14, "DIVU");
    issue(0, 3'b111, 32'd100, 32'd7);
    wait_done(0, 33, 32, 32'd2, "REMU");

    issue(0, 3'b101, 32'd5, 32'd0);
    wait_done(0, 1, 0, 32'hFFFF_FFFF, "DIVU by zero");
    issue(0, 3'b110, 32'd5, 32'd0);
    wait_done(0, 1, 0, 32'd5, "REM by zero");

    // Kill during the tenth CALC cycle
    issue(0, 3'b000, 32'd3, 32'd5);
    repeat (9) @(negedge clk);
    check("kill precondition busy", 64'(busy), 64'd1);
    kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    kill = 1'b0;
    check("kill ready", 64'(ready), 64'd1);
    check("kill busy", 64'(busy), 64'd0);
    check("kill valid", 64'(valid), 64'd0);
    check("kill result", 64'(result), 64'd5);

    // Start and kill together: a fast-path op would pulse valid if accepted
    funct3 = 3'b101; rs1 = 32'd9; rs2 = 32'd0;
    start = 1'b1; kill = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; kill = 1'b0;
    check("start+kill valid", 64'(valid), 64'd0);
    check("start+kill busy", 64'(busy), 64'd0);
    check("start+kill ready", 64'(ready), 64'd1);
    check("start+kill result", 64'(result), 64'd5);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (valid) pulses++;
      @(negedge clk);
    end
    check("kill no late valid", 64'(pulses), 64'd0);

    issue(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 1, 0, 32'h8000_0000, "DIV overflow");
    issue(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(0, 1, 0, 32'd0, "REM overflow");

    // Back-to-back issue on the UNROLL=4 unit, second start in the DONE cycle
    issue(1, 3'b101, 32'd100, 32'd7);
    wait_done(1, 9, 8, 32'd14, "U4 DIVU");
    issue(1, 3'b000, 32'd7, 32'hFFFF_FFFD);
    wait_done(1, 9, 8, 32'hFFFF_FFEB, "U4 back-to-back MUL");

    // Synchronous reset in the middle of CALC
    issue(0, 3'b100, 32'hFFFF_FFF9, 32'd2);
    wait_done(0, 33, 32, 32'hFFFF_FFFD, "DIV before reset");
    issue(0, 3'b000, 32'd7, 32'd9);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("midreset ready", 64'(ready), 64'd1);
    check("midreset busy", 64'(busy), 64'd0);
    check("midreset valid", 64'(valid), 64'd0);
    check("midreset result", 64'(result), 64'd0);
    check("midreset U4 result", 64'(result4), 64'd0);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (valid) pulses++;
      @(negedge clk);
    end
    check("midreset no late valid", 64'(pulses), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
